// File: rtl/opb_master_busint_if.sv
// Request/response and OPB bus signals of the OPB initiator.
// The master modport is the initiator's view; slave is the requester/bus-side view.
interface opb_master_busint_if;
  logic        req_valid;
  logic        req_rnw;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        m_select;
  logic        m_rnw;
  logic [15:0] m_abus;
  logic [31:0] m_dbus;
  logic [31:0] sl_dbus;
  logic        sl_xferack;

  modport master (
    input  req_valid, req_rnw, req_addr, req_wdata, sl_dbus, sl_xferack,
    output req_ready, resp_valid, resp_err, resp_rdata, busy,
           m_select, m_rnw, m_abus, m_dbus
  );

  modport slave (
    output req_valid, req_rnw, req_addr, req_wdata, sl_dbus, sl_xferack,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy,
           m_select, m_rnw, m_abus, m_dbus
  );
endinterface

// File: rtl/opb_master_busint.sv
// OPB initiator: single-beat 32-bit reads/writes with ack timeout and an
// enforced idle gap between transfers so the slave can settle.
module opb_master_busint #(
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 opb_clk,
  input  logic                 reset_n,
  opb_master_busint_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, GAP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  // Only used when GAP_CYCLES >= 2; DONE goes straight to IDLE otherwise.
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 2);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [3:0] gap_cnt;

  always_ff @(posedge opb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      gap_cnt        <= '0;
      bus.m_select   <= 1'b0;
      bus.m_rnw      <= 1'b0;
      bus.m_abus     <= '0;
      bus.m_dbus     <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.m_abus    <= bus.req_addr;
            bus.m_rnw     <= bus.req_rnw;
            bus.m_dbus    <= bus.req_rnw ? 32'h0 : bus.req_wdata;
            bus.m_select  <= 1'b1;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            bus.resp_err  <= 1'b0;
            tmo_cnt       <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (bus.sl_xferack) begin
            bus.m_select   <= 1'b0;
            if (bus.m_rnw)
              bus.resp_rdata <= bus.sl_dbus;
            bus.resp_err   <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.m_select   <= 1'b0;
            bus.resp_err   <= 1'b1;
            bus.resp_valid <= 1'b1;
            state          <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          gap_cnt <= '0;
          if (GAP_CYCLES == 1) begin
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          // The DONE cycle counts as the first gap cycle.
          if (gap_cnt == GAP_LAST) begin
            bus.busy      <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          bus.m_select  <= 1'b0;
          bus.busy      <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
